// File: rtl/ddr_rd_scheduler_if.sv
// DDR read-request channel between the line scheduler and the AXI read master.
// master: rd_req/rd_addr/rd_len out, rd_ready/rd_done in; slave is the mirror.
interface ddr_rd_scheduler_if #(
   parameter int ADDR_WIDTH = 28
);
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [7:0]            rd_len;
   logic                  rd_ready;
   logic                  rd_done;

   modport master (
      output rd_req,
      output rd_addr,
      output rd_len,
      input  rd_ready,
      input  rd_done
   );

   modport slave (
      input  rd_req,
      input  rd_addr,
      input  rd_len,
      output rd_ready,
      output rd_done
   );
endinterface

// File: rtl/ddr_rd_scheduler.sv
// Sequences DDR read bursts that build one 2x2 mosaic output line per request.
// Ports: clk/rst, line_req, frame_start, channel_en[3:0], buf_wait,
//   rd (master: rd_req/rd_addr/rd_len, rd_ready/rd_done), channel_sel[1:0],
//   blank_req, busy, line_done, frame_done, line_ovf (sticky).
module ddr_rd_scheduler #(
   parameter int DQ_WIDTH   = 32,
   parameter int H_WIDTH    = 1280,
   parameter int H_HEIGHT   = 720,
   parameter int BURST_LEN  = 16,
   parameter int ADDR_WIDTH = 28,
   parameter logic [ADDR_WIDTH-1:0] FB_BASE   = '0,
   parameter logic [ADDR_WIDTH-1:0] CH_OFFSET =
      ADDR_WIDTH'(32'h0020_0000)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                line_req,
   input  logic                frame_start,
   input  logic [3:0]          channel_en,
   input  logic                buf_wait,
   ddr_rd_scheduler_if.master  rd,
   output logic [1:0]          channel_sel,
   output logic                blank_req,
   output logic                busy,
   output logic                line_done,
   output logic                frame_done,
   output logic                line_ovf
);
   localparam int HALF_BEATS = (H_WIDTH / 2) / (DQ_WIDTH / 2);
   localparam int HALF_ROWS  = H_HEIGHT / 2;
   localparam int ROW_BYTES  = H_WIDTH;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      REQ,
      WAIT_DONE,
      NEXT
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [15:0]           r_row;
   logic [1:0]            r_ch;
   logic [15:0]           r_beat;
   logic                  r_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic                  r_pend;
   logic                  r_fs_pend;
   logic                  r_ovf;

   logic                  w_start;
   logic                  w_load;
   logic                  w_adv_ch;
   logic                  w_line_end;
   logic                  w_blank;
   logic                  w_rd_req;
   logic [15:0]           w_row_in;
   logic [1:0]            w_ch0;
   logic [15:0]           w_src;
   logic [15:0]           w_rem;
   logic [15:0]           w_beat_sum;
   logic [7:0]            w_len;
   logic [ADDR_WIDTH-1:0] w_addr;

   // frame_start in IDLE takes effect in the same cycle as a line_req
   assign w_row_in = frame_start ? 16'd0 : r_row;
   assign w_ch0    = (w_row_in < 16'(HALF_ROWS)) ? 2'd0 : 2'd2;

   // bottom-half rows fetch source row (row - H/2) of channels 2/3
   assign w_src = (r_row >= 16'(HALF_ROWS)) ?
                  r_row - 16'(HALF_ROWS) : r_row;

   assign w_rem = 16'(HALF_BEATS) - r_beat;
   assign w_len = (w_rem > 16'(BURST_LEN)) ?
                  8'(BURST_LEN - 1) : 8'(w_rem - 16'd1);

   assign w_addr = FB_BASE
                 + ADDR_WIDTH'(r_ch) * CH_OFFSET
                 + ADDR_WIDTH'(w_src) * ADDR_WIDTH'(ROW_BYTES)
                 + ADDR_WIDTH'(r_beat) * ADDR_WIDTH'(DQ_WIDTH);

   assign w_beat_sum = r_beat + {8'd0, r_len} + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_adv_ch    = 1'b0;
      w_line_end  = 1'b0;
      w_blank     = 1'b0;
      w_rd_req    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (line_req || r_pend) begin
               w_start     = 1'b1;
               w_state_nxt = SEL;
            end
         end
         SEL: begin
            if (!r_en) begin
               w_blank     = 1'b1;
               w_state_nxt = NEXT;
            end else if (!buf_wait) begin
               w_load      = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            w_rd_req = 1'b1;
            if (rd.rd_ready) w_state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (rd.rd_done) begin
               if (w_beat_sum < 16'(HALF_BEATS))
                  w_state_nxt = SEL;
               else
                  w_state_nxt = NEXT;
            end
         end
         NEXT: begin
            if (!r_ch[0]) begin
               w_adv_ch    = 1'b1;
               w_state_nxt = SEL;
            end else begin
               w_line_end  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_row     <= '0;
         r_ch      <= '0;
         r_beat    <= '0;
         r_en      <= 1'b0;
         r_addr    <= '0;
         r_len     <= '0;
         r_pend    <= 1'b0;
         r_fs_pend <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_row     <= w_row_in;
            r_fs_pend <= 1'b0;
         end else if (w_line_end) begin
            // a frame_start seen during the line overrides the increment
            if (r_fs_pend || frame_start ||
                r_row == 16'(H_HEIGHT - 1))
               r_row <= '0;
            else
               r_row <= r_row + 16'd1;
            r_fs_pend <= 1'b0;
         end else if (frame_start) begin
            r_fs_pend <= 1'b1;
         end

         if (w_start) begin
            r_ch   <= w_ch0;
            r_beat <= '0;
            r_en   <= channel_en[w_ch0];
         end else if (w_adv_ch) begin
            r_ch   <= r_ch + 2'd1;
            r_beat <= '0;
            r_en   <= channel_en[r_ch + 2'd1];
         end else if (r_state == WAIT_DONE && rd.rd_done) begin
            r_beat <= w_beat_sum;
         end

         if (w_load) begin
            r_addr <= w_addr;
            r_len  <= w_len;
         end

         // one-deep request queue; a second queued request is dropped
         if (r_state == IDLE) begin
            r_pend <= r_pend & line_req;
         end else if (line_req) begin
            if (r_pend) r_ovf  <= 1'b1;
            else        r_pend <= 1'b1;
         end
      end
   end

   assign rd.rd_req   = w_rd_req;
   assign rd.rd_addr  = r_addr;
   assign rd.rd_len   = r_len;
   assign channel_sel = r_ch;
   assign blank_req   = w_blank;
   assign busy        = (r_state != IDLE);
   assign line_done   = w_line_end;
   assign frame_done  = w_line_end && (r_row == 16'(H_HEIGHT - 1));
   assign line_ovf    = r_ovf;
endmodule

// File: tb/tb_ddr_rd_scheduler.sv
// Scoreboard bench for ddr_rd_scheduler: expected bursts/blanks queued per line,
// compared as the DUT issues them; a small responder plays the AXI read master.
module tb_ddr_rd_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_req = 1'b0;
   logic       frame_start = 1'b0;
   logic       buf_wait = 1'b0;
   logic [3:0] channel_en = 4'hF;
   logic [1:0] channel_sel;
   logic       blank_req;
   logic       busy;
   logic       line_done;
   logic       frame_done;
   logic       line_ovf;

   ddr_rd_scheduler_if #(.ADDR_WIDTH(28)) bus();

   ddr_rd_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .line_req    (line_req),
      .frame_start (frame_start),
      .channel_en  (channel_en),
      .buf_wait    (buf_wait),
      .rd          (bus),
      .channel_sel (channel_sel),
      .blank_req   (blank_req),
      .busy        (busy),
      .line_done   (line_done),
      .frame_done  (frame_done),
      .line_ovf    (line_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          blank;
      logic [27:0] addr;
      logic [7:0]  len;
      logic [1:0]  ch;
   } exp_t;

   exp_t sb[$];
   bit   fd_q[$];

   int n_chk  = 0;
   int n_pass = 0;
   int m_row  = 0;
   int g_rdly = 0;
   int g_bw_pre = 0;
   bit g_bw_mid = 1'b0;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
   endtask

   task automatic push_line();
      int row;
      int src;
      int ch;
      bit top;
      exp_t e;
      row = m_row;
      top = (row < 360);
      src = top ? row : row - 360;
      fd_q.push_back(row == 719);
      for (int k = 0; k < 2; k++) begin
         ch = top ? k : k + 2;
         if (channel_en[ch]) begin
            for (int b = 0; b < 40; b += 16) begin
               e.blank = 1'b0;
               e.ch    = 2'(ch);
               e.len   = 8'((((40 - b) > 16) ? 16 : (40 - b)) - 1);
               e.addr  = 28'(ch * 32'h200000 + src * 1280 + b * 32);
               sb.push_back(e);
            end
         end else begin
            e.blank = 1'b1;
            e.ch    = 2'(ch);
            e.addr  = '0;
            e.len   = '0;
            sb.push_back(e);
         end
      end
      m_row = (row == 719) ? 0 : row + 1;
   endtask

   task automatic run(input int ndone, input bit start,
                      input bit fs0, input int inj_a,
                      input int inj_b, input int fs_mid);
      int   cyc = 0;
      int   seen = 0;
      int   wcnt = 0;
      int   dcnt = 0;
      bit   waiting = 1'b0;
      bit   fd;
      exp_t e;
      while (seen < ndone) begin
         @(negedge clk);
         line_req     = 1'b0;
         frame_start  = 1'b0;
         bus.rd_ready = 1'b0;
         bus.rd_done  = 1'b0;
         if (cyc == 0 && start) begin
            line_req = 1'b1;
            if (fs0) begin
               frame_start = 1'b1;
               m_row = 0;
            end
            push_line();
         end
         if (cyc == inj_a) begin
            line_req = 1'b1;
            push_line();
         end
         if (cyc == inj_b) line_req = 1'b1;
         if (cyc == fs_mid) begin
            frame_start = 1'b1;
            m_row = 0;
         end
         buf_wait = (cyc < g_bw_pre) || (g_bw_mid && waiting);
         if (cyc > 0 && cyc < g_bw_pre)
            chk("bw_block", bus.rd_req, 0);
         if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) bus.rd_done = 1'b1;
         end
         if (blank_req) begin
            if (sb.size() == 0) chk("blank_unexp", 1, 0);
            else begin
               e = sb.pop_front();
               chk("blank_kind", e.blank, 1);
               chk("blank_ch", channel_sel, e.ch);
            end
         end
         if (bus.rd_req) begin
            if (sb.size() == 0) begin
               chk("req_unexp", 1, 0);
               bus.rd_ready = 1'b1;
               dcnt = 1;
            end else begin
               e = sb[0];
               chk("kind", e.blank, 0);
               chk("addr", bus.rd_addr, e.addr);
               chk("len", bus.rd_len, e.len);
               chk("ch", channel_sel, e.ch);
               if (wcnt >= g_rdly) begin
                  bus.rd_ready = 1'b1;
                  void'(sb.pop_front());
                  dcnt = 1;
                  wcnt = 0;
                  waiting = 1'b0;
               end else begin
                  wcnt++;
                  waiting = 1'b1;
               end
            end
         end else if (waiting) begin
            chk("req_held", 0, 1);
            waiting = 1'b0;
            wcnt = 0;
         end
         if (line_done) begin
            seen++;
            if (fd_q.size() == 0) chk("ld_unexp", 1, 0);
            else begin
               fd = fd_q.pop_front();
               chk("frame_done", frame_done, fd);
            end
         end else if (frame_done) begin
            chk("fd_spur", 1, 0);
         end
         cyc++;
         if (cyc > 400 * ndone) begin
            chk("timeout", 0, 1);
            break;
         end
      end
      line_req     = 1'b0;
      frame_start  = 1'b0;
      bus.rd_ready = 1'b0;
      bus.rd_done  = 1'b0;
      buf_wait     = 1'b0;
      chk("sb_drain", sb.size(), 0);
   endtask

   initial begin
      int n;
      bus.rd_ready = 1'b0;
      bus.rd_done  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sel", channel_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req", bus.rd_req, 0);
      chk("rst_ld", line_done, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_ovf", line_ovf, 0);
      chk("rst_blank", blank_req, 0);
      rst = 1'b0;

      run(1, 1, 0, -1, -1, -1);
      @(negedge clk);
      chk("busy_idle", busy, 0);
      chk("sel_hold", channel_sel, 1);

      for (int r = 1; r <= 5; r++) run(1, 1, 0, -1, -1, -1);

      g_bw_pre = 5;
      run(1, 1, 0, -1, -1, -1);
      g_bw_pre = 0;
      g_bw_mid = 1'b1;
      g_rdly   = 3;
      run(1, 1, 0, -1, -1, -1);
      g_bw_mid = 1'b0;
      g_rdly   = 0;

      for (int r = 8; r <= 360; r++) run(1, 1, 0, -1, -1, -1);

      run(2, 1, 0, 4, 8, -1);
      chk("ovf_set", line_ovf, 1);

      for (int r = 363; r <= 719; r++) run(1, 1, 0, -1, -1, -1);
      run(1, 1, 0, -1, -1, -1);
      chk("ovf_sticky", line_ovf, 1);

      for (int r = 1; r <= 99; r++) run(1, 1, 0, -1, -1, -1);
      run(1, 1, 0, -1, -1, 5);
      run(1, 1, 0, -1, -1, -1);

      channel_en = 4'b1101;
      run(1, 1, 1, -1, -1, -1);
      channel_en = 4'hF;

      @(negedge clk);
      line_req = 1'b1;
      n = 0;
      while (!bus.rd_req && n < 50) begin
         @(negedge clk);
         line_req = 1'b0;
         n++;
      end
      if (n >= 50) chk("rst_timeout", 0, 1);
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.rd_ready = 1'b0;
      chk("wait_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req", bus.rd_req, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ovf", line_ovf, 0);
      rst = 1'b0;
      bus.rd_done = 1'b1;
      @(negedge clk);
      bus.rd_done = 1'b0;
      chk("stale_busy", busy, 0);
      chk("stale_req", bus.rd_req, 0);
      repeat (3) @(negedge clk);
      chk("stale_req2", bus.rd_req, 0);
      sb.delete();
      fd_q.delete();
      m_row = 0;
      run(1, 1, 0, -1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
